// File: rtl/user_gpio_irq_ctrl.sv
// GPIO edge-interrupt controller: tick-filtered pin levels, enabled edge detection,
// W1C pending bits and a single registered level interrupt, serviced over an OBI port.
module user_gpio_irq_ctrl #(
    parameter int unsigned GpioCount  = 16,
    parameter int unsigned PrescWidth = 16,
    parameter int unsigned IdWidth    = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [GpioCount-1:0] gpio_i,
    input  logic                 obi_req_i,
    output logic                 obi_gnt_o,
    input  logic [31:0]          obi_addr_i,
    input  logic                 obi_we_i,
    input  logic [3:0]           obi_be_i,
    input  logic [31:0]          obi_wdata_i,
    input  logic [IdWidth-1:0]   obi_aid_i,
    output logic                 obi_rvalid_o,
    output logic [31:0]          obi_rdata_o,
    output logic [IdWidth-1:0]   obi_rid_o,
    output logic                 obi_err_o,
    output logic                 irq_o
);

    localparam logic [2:0] OffRiseEn  = 3'd0;
    localparam logic [2:0] OffFallEn  = 3'd1;
    localparam logic [2:0] OffPending = 3'd2;
    localparam logic [2:0] OffLevel   = 3'd3;
    localparam logic [2:0] OffPresc   = 3'd4;

    logic [GpioCount-1:0]  r_rise_en;
    logic [GpioCount-1:0]  r_fall_en;
    logic [GpioCount-1:0]  r_pending;
    logic [GpioCount-1:0]  r_samp;
    logic [GpioCount-1:0]  r_filt;
    logic [PrescWidth-1:0] r_presc;
    logic [PrescWidth-1:0] r_cnt;
    logic                  r_irq;
    logic                  r_rvalid;
    logic [31:0]           r_rdata;
    logic [IdWidth-1:0]    r_rid;
    logic                  r_err;

    logic [2:0]           w_idx;
    logic                 w_wr;
    logic                 w_bad;
    logic [31:0]          w_wmask;
    logic [31:0]          w_rdata;
    logic                 w_tick;
    logic [GpioCount-1:0] w_stable;
    logic [GpioCount-1:0] w_filt_d;
    logic [GpioCount-1:0] w_set;
    logic [GpioCount-1:0] w_clr;
    logic [GpioCount-1:0] w_pend_d;
    logic                 w_unused_addr;

    assign obi_gnt_o     = obi_req_i;
    assign w_idx         = obi_addr_i[4:2];
    assign w_wr          = obi_req_i & obi_we_i;
    assign w_bad         = (w_idx > OffPresc);
    assign w_unused_addr = ^{obi_addr_i[31:5], obi_addr_i[1:0]};

    assign w_wmask = {{8{obi_be_i[3]}}, {8{obi_be_i[2]}}, {8{obi_be_i[1]}}, {8{obi_be_i[0]}}};

    function automatic logic [31:0] merge(input logic [31:0] old_val, input logic [31:0] new_val,
                                          input logic [31:0] mask);
        return (old_val & ~mask) | (new_val & mask);
    endfunction

    always_comb begin
        w_rdata = 32'd0;
        case (w_idx)
            OffRiseEn:  w_rdata = 32'(r_rise_en);
            OffFallEn:  w_rdata = 32'(r_fall_en);
            OffPending: w_rdata = 32'(r_pending);
            OffLevel:   w_rdata = 32'(r_filt);
            OffPresc:   w_rdata = 32'(r_presc);
            default:    w_rdata = 32'd0;
        endcase
    end

    // Filter: a pin's filtered level follows gpio_i only once two consecutive ticks agree.
    assign w_tick   = (r_cnt == r_presc);
    assign w_stable = ~(gpio_i ^ r_samp);
    assign w_filt_d = w_tick ? ((r_filt & ~w_stable) | (gpio_i & w_stable)) : r_filt;

    assign w_set    = (w_filt_d & ~r_filt & r_rise_en) | (~w_filt_d & r_filt & r_fall_en);
    assign w_clr    = (w_wr && w_idx == OffPending) ?
                      GpioCount'(obi_wdata_i & w_wmask) : '0;
    // Set is OR-ed after the clear so a same-cycle edge is never lost.
    assign w_pend_d = (r_pending & ~w_clr) | w_set;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rise_en <= '0;
            r_fall_en <= '0;
            r_presc   <= '0;
        end else if (w_wr) begin
            if (w_idx == OffRiseEn) begin
                r_rise_en <= GpioCount'(merge(32'(r_rise_en), obi_wdata_i, w_wmask));
            end
            if (w_idx == OffFallEn) begin
                r_fall_en <= GpioCount'(merge(32'(r_fall_en), obi_wdata_i, w_wmask));
            end
            if (w_idx == OffPresc) begin
                r_presc <= PrescWidth'(merge(32'(r_presc), obi_wdata_i, w_wmask));
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (w_wr && w_idx == OffPresc) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + PrescWidth'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_samp    <= '0;
            r_filt    <= '0;
            r_pending <= '0;
            r_irq     <= 1'b0;
        end else begin
            if (w_tick) begin
                r_samp <= gpio_i;
            end
            r_filt    <= w_filt_d;
            r_pending <= w_pend_d;
            r_irq     <= |r_pending;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rvalid <= 1'b0;
            r_rdata  <= 32'd0;
            r_rid    <= '0;
            r_err    <= 1'b0;
        end else begin
            r_rvalid <= obi_req_i;
            if (obi_req_i) begin
                r_rid   <= obi_aid_i;
                r_err   <= w_bad;
                r_rdata <= obi_we_i ? 32'd0 : w_rdata;
            end else begin
                r_err <= 1'b0;
            end
        end
    end

    assign obi_rvalid_o = r_rvalid;
    assign obi_rdata_o  = r_rdata;
    assign obi_rid_o    = r_rid;
    assign obi_err_o    = r_err;
    assign irq_o        = r_irq;

endmodule

// File: tb/tb_user_gpio_irq_ctrl.sv
// Scoreboard bench for user_gpio_irq_ctrl: OBI responses checked against queued expectations,
// pending/level/irq behaviour checked against hand-derived cycle timing.
module tb_user_gpio_irq_ctrl;

    logic        clk;
    logic        rst;
    logic [15:0] gpio;
    logic        obi_req;
    logic        obi_gnt;
    logic [31:0] obi_addr;
    logic        obi_we;
    logic [3:0]  obi_be;
    logic [31:0] obi_wdata;
    logic [0:0]  obi_aid;
    logic        obi_rvalid;
    logic [31:0] obi_rdata;
    logic [0:0]  obi_rid;
    logic        obi_err;
    logic        irq;

    typedef struct {
        string       tag;
        logic [31:0] rdata;
        logic        err;
        logic [0:0]  rid;
        logic        is_rd;
    } exp_t;

    exp_t       sb_q[$];
    logic [0:0] aid_q;
    int         n_chk;
    int         n_pass;

    user_gpio_irq_ctrl #(
        .GpioCount (16),
        .PrescWidth(16),
        .IdWidth   (1)
    ) u_dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .gpio_i      (gpio),
        .obi_req_i   (obi_req),
        .obi_gnt_o   (obi_gnt),
        .obi_addr_i  (obi_addr),
        .obi_we_i    (obi_we),
        .obi_be_i    (obi_be),
        .obi_wdata_i (obi_wdata),
        .obi_aid_i   (obi_aid),
        .obi_rvalid_o(obi_rvalid),
        .obi_rdata_o (obi_rdata),
        .obi_rid_o   (obi_rid),
        .obi_err_o   (obi_err),
        .irq_o       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Response monitor: every rvalid pops one expectation.
    always @(negedge clk) begin
        if (!rst && obi_rvalid) begin
            if (sb_q.size() == 0) begin
                chk("spurious_rvalid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk({e.tag, "_rid"}, 32'(obi_rid), 32'(e.rid));
                chk({e.tag, "_err"}, 32'(obi_err), 32'(e.err));
                if (e.is_rd) chk(e.tag, obi_rdata, e.rdata);
            end
        end
    end

    task automatic obi_op(input string tag, input logic we, input logic [31:0] addr,
                          input logic [3:0] be, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err);
        exp_t e;
        obi_req   = 1'b1;
        obi_we    = we;
        obi_addr  = addr;
        obi_be    = be;
        obi_wdata = wdata;
        obi_aid   = aid_q;
        e.tag     = tag;
        e.rdata   = exp_rdata;
        e.err     = exp_err;
        e.rid     = aid_q;
        e.is_rd   = !we;
        sb_q.push_back(e);
        aid_q = ~aid_q;
        #1 chk({tag, "_gnt"}, 32'(obi_gnt), 32'd1);
        @(posedge clk);
        @(negedge clk);
        obi_req = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp,
                      input logic err = 1'b0);
        obi_op(tag, 1'b0, addr, 4'hF, 32'd0, exp, err);
    endtask

    task automatic wr(input string tag, input logic [31:0] addr, input logic [3:0] be,
                      input logic [31:0] data, input logic err = 1'b0);
        obi_op(tag, 1'b1, addr, be, data, 32'd0, err);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0; n_pass = 0; aid_q = 1'b0;
        rst = 1'b1; gpio = '0;
        obi_req = 0; obi_we = 0; obi_addr = 0; obi_be = 0; obi_wdata = 0; obi_aid = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset drops an in-flight response
        obi_req = 1'b1; obi_we = 1'b0; obi_addr = 32'h0;
        @(posedge clk);
        #1 rst = 1'b1;
        obi_req = 1'b0;
        @(negedge clk);
        chk("rst_rvalid", 32'(obi_rvalid), 32'd0);
        chk("rst_rdata", obi_rdata, 32'd0);
        chk("rst_rid", 32'(obi_rid), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_no_resp", 32'(obi_rvalid), 32'd0);

        // 1: reset values and out-of-range read
        rd("rst_rise_en", 32'h00, 32'h0);
        rd("rst_fall_en", 32'h04, 32'h0);
        rd("rst_pending", 32'h08, 32'h0);
        rd("rst_level",   32'h0C, 32'h0);
        rd("rst_presc",   32'h10, 32'h0);
        rd("bad_rd_14",   32'h14, 32'h0, 1'b1);

        // 2: PRESC=0, rising edge on pin0
        wr("wr_rise_en", 32'h00, 4'hF, 32'h1);
        gpio[0] = 1'b1;
        @(negedge clk);
        rd("t2_pend_early", 32'h08, 32'h0);
        chk("t2_irq_low", 32'(irq), 32'd0);
        rd("t2_pend_set", 32'h08, 32'h1);
        chk("t2_irq_high", 32'(irq), 32'd1);
        rd("t2_level", 32'h0C, 32'h1);

        // 3: PRESC=3, glitch filtered, sustained fall detected
        gpio[15] = 1'b1;
        repeat (4) @(negedge clk);
        wr("wr_fall_en", 32'h04, 4'hF, 32'h8000);
        wr("wr_presc3", 32'h10, 4'hF, 32'h3);
        gpio[15] = 1'b0;
        @(negedge clk);
        gpio[15] = 1'b1;
        repeat (12) @(negedge clk);
        rd("t3_glitch", 32'h08, 32'h0001);
        gpio[15] = 1'b0;
        repeat (8) @(negedge clk);
        rd("t3_pend_fall", 32'h08, 32'h8001);
        rd("t3_level", 32'h0C, 32'h0001);

        // 4: W1C one bit at a time
        wr("wr_rise_en3", 32'h00, 4'hF, 32'h3);
        wr("clr_8000", 32'h08, 4'hF, 32'h8000);
        gpio[1] = 1'b1;
        repeat (12) @(negedge clk);
        rd("t4_pend3", 32'h08, 32'h0003);
        wr("clr_1", 32'h08, 4'hF, 32'h1);
        rd("t4_pend2", 32'h08, 32'h0002);
        chk("t4_irq_stay", 32'(irq), 32'd1);
        wr("clr_2", 32'h08, 4'hF, 32'h2);
        chk("t4_irq_lag", 32'(irq), 32'd1);
        @(negedge clk);
        chk("t4_irq_fall", 32'(irq), 32'd0);
        rd("t4_pend0", 32'h08, 32'h0);

        // 5: edge and W1C of the same bit in one cycle
        wr("wr_presc0", 32'h10, 4'hF, 32'h0);
        gpio[0] = 1'b0;
        repeat (4) @(negedge clk);
        rd("t5_pend_pre", 32'h08, 32'h0);
        gpio[0] = 1'b1;
        @(negedge clk);
        wr("t5_clr_race", 32'h08, 4'hF, 32'h1);
        rd("t5_set_wins", 32'h08, 32'h1);
        chk("t5_irq", 32'(irq), 32'd1);
        wr("t5_dis_rise", 32'h00, 4'hF, 32'h0);
        rd("t5_pend_kept", 32'h08, 32'h1);

        // 6: byte enables, back-to-back, unused bits, ignored/err writes
        wr("t6_presc_be", 32'h10, 4'b0001, 32'hFFFF);
        rd("t6_presc_rd", 32'h10, 32'h00FF);
        wr("t6_rise_all", 32'h00, 4'hF, 32'hFFFF_FFFF);
        rd("t6_rise_rd", 32'h00, 32'h0000_FFFF);
        wr("t6_wr_level", 32'h0C, 4'hF, 32'hFFFF);
        rd("t6_level_rd", 32'h0C, 32'h0003);
        wr("t6_bad_wr", 32'h18, 4'hF, 32'hFFFF, 1'b1);
        rd("t6_bad_rd", 32'h1C, 32'h0, 1'b1);
        rd("t6_fall_rd", 32'h04, 32'h8000);

        for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
        chk("sb_drain", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
